aes_job_ctrl: RTL

// - Job sequencer for the streaming AES-128 engine: turns a register-file trigger into the engine's

---
 rtl/aes_job_ctrl.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/aes_job_ctrl.sv
// ---------------------------------------------------------------------------
// aes_job_ctrl
//
// Job sequencer for the streaming AES-128 engine. A trigger from the register
// file starts a job of N 128-bit blocks. The sequencer then soft-clears the
// engine, starts the engine and the sink streamer, and counts the 32-bit
// output words. After the last word has been handshaked, it waits for the
// streamer to finish and then reports completion.
//
// Optional feature: define AES_CTRL_WDT_EN to enable the stall watchdog.
//   If RUN/DRAIN sees no out_hs_i and no streamer_done_i for WDT_CYCLES
//   consecutive cycles, the job is aborted and timeout_o pulses.
//   If the macro is undefined, timeout_o is tied to 0.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   trigger_i          job start pulse
//   abort_i            software abort pulse
//   cfg_nblocks_i      blocks per job, sampled when a trigger is accepted
//   out_hs_i           engine output word handshake
//   streamer_done_i    sink streamer finished (pulse or level)
//   engine_clear_o     engine soft clear (CLEAR and ABORT states)
//   engine_enable_o    engine enable (START/RUN/DRAIN states)
//   engine_start_o     engine start pulse (START state)
//   engine_len_o       latched job length in words
//   streamer_start_o   sink streamer start pulse (START state)
//   busy_o             any state other than IDLE
//   progress_o         words handshaked in the current/last job
//   done_o             job complete pulse
//   err_o              pulse for a rejected trigger (nblocks == 0)
//   timeout_o          watchdog abort pulse
//
// Handshake: out_hs_i is taken as one completed word transfer in every
// cycle it is high while in RUN. It is ignored in all other states.
// All outputs are registered, and every FSM output is decoded from the
// next state, so each output lines up with the state it belongs to.
// ---------------------------------------------------------------------------
module aes_job_ctrl #(
    parameter int unsigned BLK_CNT_W     = 16,
    parameter int unsigned WORDS_PER_BLK = 4,
    parameter int unsigned WDT_CYCLES    = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 trigger_i,
    input  logic                 abort_i,
    input  logic [BLK_CNT_W-1:0] cfg_nblocks_i,
    input  logic                 out_hs_i,
    input  logic                 streamer_done_i,
    output logic                 engine_clear_o,
    output logic                 engine_enable_o,
    output logic                 engine_start_o,
    output logic [BLK_CNT_W+1:0] engine_len_o,
    output logic                 streamer_start_o,
    output logic                 busy_o,
    output logic [BLK_CNT_W+1:0] progress_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 timeout_o
);

    localparam int unsigned LEN_W     = BLK_CNT_W + 2;
    localparam int unsigned BLK_SHIFT = $clog2(WORDS_PER_BLK);

    // Parameter sanity checks, evaluated at elaboration.
    if (WORDS_PER_BLK != (32'd1 << BLK_SHIFT)) begin : g_bad_wpb
        $error("WORDS_PER_BLK must be a power of two");
    end
    if (WDT_CYCLES < 2) begin : g_bad_wdt
        $error("WDT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5,
        ST_ABORT = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   prog_q, prog_d;
    logic               seen_q, seen_d;     // streamer_done_i already seen in this job
    logic               err_d;
    logic               tmo_d;
    logic               wdt_fire;

    logic               clear_q, enable_q, start_q, sstart_q, busy_q, done_q, err_q, tmo_q;

    // -----------------------------------------------------------------------
    // Stall watchdog
    // -----------------------------------------------------------------------
`ifdef AES_CTRL_WDT_EN
    localparam int unsigned WDT_W = $clog2(WDT_CYCLES);

    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic             wdt_active;

    assign wdt_active = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    // Fires on the last idle cycle of a WDT_CYCLES-long stall.
    assign wdt_fire = wdt_active && !out_hs_i && !streamer_done_i &&
                      (wdt_q == WDT_W'(WDT_CYCLES - 1));

    // The counter restarts on any activity and on every state change, so
    // each RUN/DRAIN entry starts counting again from zero.
    always_comb begin
        wdt_d = '0;
        if (wdt_active && (state_d == state_q) && !out_hs_i && !streamer_done_i) begin
            wdt_d = wdt_q + WDT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_d;
        end
    end
`else
    assign wdt_fire = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        prog_d  = prog_q;
        seen_d  = seen_q;
        err_d   = 1'b0;
        tmo_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // If abort arrives in the same cycle, it cancels the trigger.
                if (trigger_i && !abort_i) begin
                    if (cfg_nblocks_i == '0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_CLEAR;
                        len_d   = LEN_W'(cfg_nblocks_i) << BLK_SHIFT;
                        prog_d  = '0;
                        seen_d  = 1'b0;
                    end
                end
            end

            ST_CLEAR: begin
                state_d = abort_i ? ST_IDLE : ST_START;
            end

            ST_START: begin
                if (streamer_done_i) seen_d = 1'b1;
                state_d = abort_i ? ST_ABORT : ST_RUN;
            end

            ST_RUN: begin
                if (streamer_done_i) seen_d = 1'b1;
                if (abort_i) begin
                    state_d = ST_ABORT;
                end else if (wdt_fire) begin
                    state_d = ST_ABORT;
                    tmo_d   = 1'b1;
                end else if (out_hs_i && (prog_q < len_q)) begin
                    prog_d = prog_q + LEN_W'(1);
                    if (prog_d == len_q) state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if (streamer_done_i) seen_d = 1'b1;
                if (abort_i) begin
                    state_d = ST_ABORT;
                end else if (seen_q || streamer_done_i) begin
                    state_d = ST_DONE;
                end else if (wdt_fire) begin
                    state_d = ST_ABORT;
                    tmo_d   = 1'b1;
                end
            end

            ST_DONE:  state_d = ST_IDLE;
            ST_ABORT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            prog_q   <= '0;
            seen_q   <= 1'b0;
            clear_q  <= 1'b0;
            enable_q <= 1'b0;
            start_q  <= 1'b0;
            sstart_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            prog_q   <= prog_d;
            seen_q   <= seen_d;
            clear_q  <= (state_d == ST_CLEAR) || (state_d == ST_ABORT);
            enable_q <= (state_d == ST_START) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
            start_q  <= (state_d == ST_START);
            sstart_q <= (state_d == ST_START);
            busy_q   <= (state_d != ST_IDLE);
            done_q   <= (state_d == ST_DONE);
            err_q    <= err_d;
            tmo_q    <= tmo_d;
        end
    end

    assign engine_clear_o   = clear_q;
    assign engine_enable_o  = enable_q;
    assign engine_start_o   = start_q;
    assign streamer_start_o = sstart_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign err_o            = err_q;
    assign engine_len_o     = len_q;
    assign progress_o       = prog_q;
`ifdef AES_CTRL_WDT_EN
    assign timeout_o        = tmo_q;
`else
    assign timeout_o        = 1'b0;
`endif

endmodule
